// File: rtl/led_matrix_scan_controller_pkg.sv
// Shared definitions for the 5x7 LED matrix scan controller.
// Matrix geometry, status codes, scan FSM states and a column mask helper.
package led_matrix_pkg;

   localparam int NUM_COLS = 5;
   localparam int NUM_ROWS = 7;

   localparam logic [1:0] ST_IDLE     = 2'b00;
   localparam logic [1:0] ST_WATERING = 2'b01;
   localparam logic [1:0] ST_DONE     = 2'b10;
   localparam logic [1:0] ST_FAULT    = 2'b11;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   // Active-low enable pattern with only column idx driven low.
   function automatic logic [NUM_COLS-1:0] col_mask(input logic [2:0] idx);
      logic [NUM_COLS-1:0] m;
      for (int i = 0; i < NUM_COLS; i++)
         m[i] = (idx != 3'(i));
      return m;
   endfunction

endpackage

// File: rtl/led_matrix_scan_controller_if.sv
// Bundle between the scan controller and the matrix / column decoders.
// master: controller side; slave: decoders and LED drivers side.
interface led_matrix_scan_controller_if;
   import led_matrix_pkg::*;

   logic [1:0]                   irrigation_status;
   logic [NUM_COLS*NUM_ROWS-1:0] column_images;
   logic [1:0]                   status_frame;
   logic [NUM_COLS-1:0]          columns;
   logic [NUM_ROWS-1:0]          rows;
   logic                         frame_start;

   modport master (
      input  irrigation_status,
      input  column_images,
      output status_frame,
      output columns,
      output rows,
      output frame_start
   );

   modport slave (
      output irrigation_status,
      output column_images,
      input  status_frame,
      input  columns,
      input  rows,
      input  frame_start
   );

endinterface

// File: rtl/led_matrix_blink_timer.sv
// Fault blink timer: toggles blink_on every BLINK_FRAMES frames.
// Ports: clk, reset, i_frame_wrap, i_fault (code shown this frame), o_blink_on.
module led_matrix_blink_timer #(
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic i_frame_wrap,
   input  logic i_fault,
   output logic o_blink_on
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] r_frame_cnt;
   logic             r_blink_on;

   // Non-fault frames hold the timer in the visible phase, so a fresh
   // fault always begins with a full visible half-period.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (i_frame_wrap) begin
         if (!i_fault) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
         end else if (r_frame_cnt == CNT_LAST) begin
            r_frame_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign o_blink_on = r_blink_on;

endmodule

// File: rtl/led_matrix_scan_controller.sv
// Time-multiplexed 5x7 LED scan with per-column blanking and fault blink.
// Ports: clk, reset (sync, active-high), bus (master modport of the matrix if).
module led_matrix_scan_controller
   import led_matrix_pkg::*;
#(
   parameter int CLK_DIV      = 5000,
   parameter int BLANK_CYCLES = 50,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   led_matrix_scan_controller_if.master bus
);

   localparam int SLOT_W = $clog2(CLK_DIV);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
   localparam logic [2:0]        COL_LAST   = 3'(NUM_COLS - 1);

   scan_state_t         r_state;
   logic [2:0]          r_col_idx;
   logic [SLOT_W-1:0]   r_slot_cnt;
   logic [1:0]          r_status_frame;
   logic [NUM_COLS-1:0] r_columns;
   logic [NUM_ROWS-1:0] r_rows;
   logic                r_frame_start;

   logic                w_slot_end;
   logic                w_frame_wrap;
   logic                w_fault;
   logic                w_blink_on;
   logic                w_dark;
   logic [NUM_ROWS-1:0] w_image;

   assign w_slot_end   = (r_state == SHOW) && (r_slot_cnt == SLOT_LAST);
   assign w_frame_wrap = w_slot_end && (r_col_idx == COL_LAST);
   assign w_fault      = (r_status_frame == ST_FAULT);
   assign w_dark       = w_fault && !w_blink_on;
   assign w_image      = bus.column_images[r_col_idx*NUM_ROWS +: NUM_ROWS];

   led_matrix_blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk          (clk),
      .reset        (reset),
      .i_frame_wrap (w_frame_wrap),
      .i_fault      (w_fault),
      .o_blink_on   (w_blink_on)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= BLANK;
         r_col_idx      <= '0;
         r_slot_cnt     <= '0;
         r_status_frame <= ST_IDLE;
         r_columns      <= '1;
         r_rows         <= '0;
         r_frame_start  <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_slot_cnt    <= r_slot_cnt + 1'b1;
         unique case (r_state)
            BLANK: begin
               // Image is sampled once here and held for the whole show.
               if (r_slot_cnt == BLANK_LAST) begin
                  r_state   <= SHOW;
                  r_rows    <= w_dark ? '0 : w_image;
                  r_columns <= col_mask(r_col_idx);
               end
            end
            SHOW: begin
               if (w_slot_end) begin
                  r_state    <= BLANK;
                  r_slot_cnt <= '0;
                  r_columns  <= '1;
                  r_rows     <= '0;
                  if (r_col_idx == COL_LAST) begin
                     // Relatch only here so decoders settle during blank.
                     r_col_idx      <= '0;
                     r_status_frame <= bus.irrigation_status;
                     r_frame_start  <= 1'b1;
                  end else begin
                     r_col_idx <= r_col_idx + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.status_frame = r_status_frame;
   assign bus.columns      = r_columns;
   assign bus.rows         = r_rows;
   assign bus.frame_start  = r_frame_start;

endmodule

// File: doc/led_matrix_scan_controller.md
Name: led_matrix_scan_controller

Overview:
- Time-multiplexed scan controller for the 5x7 LED matrix that shows the irrigation status.
- Holds the status code stable for a whole frame and feeds it to the per-column status decoders.
- Collects their 7-bit row images and drives one column at a time, with a blanking gap between columns to prevent ghosting.
- Blinks the whole image when the status code is the fault code (2'b11).

Parameters:
- CLK_DIV, 5000: clock cycles per column slot (blank plus show); legal range > BLANK_CYCLES.
- BLANK_CYCLES, 50: cycles at the start of each slot with all columns off; legal range ≥ 1.
- BLINK_FRAMES, 32: frames per blink half-period while the fault code is latched; legal range ≥ 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irrigation_status  input  2  live status code from the irrigation FSM
- column_images  input  35  decoder row images; column c occupies bits [7c+6:7c], row r at bit 7c+r
- status_frame  output  2  status code latched for the current frame; drives every column decoder
- columns  output  5  column enables, active-low, at most one low at any time
- rows  output  7  row data, active-high
- frame_start  output  1  one-cycle pulse when a new frame begins (status relatched)

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; every register is updated only on the rising edge of clk.
- Reset values:
  - columns=5'b11111, rows=7'b0, status_frame=2'b00, frame_start=0.
  - Internal: state=BLANK, col_idx=0, slot_cnt=0, frame_cnt=0, blink_on=1.
- Reset asserted mid-scan takes effect on the next edge: all outputs return to their reset values that cycle, and the scan restarts from column 0 BLANK.
- State machine has two states, BLANK and SHOW. slot_cnt counts 0..CLK_DIV-1 within a slot.
- BLANK:
  - columns=5'b11111, rows=0.
  - Transition to SHOW when slot_cnt==BLANK_CYCLES-1.
  - On that edge, rows is loaded with column_images[7*col_idx +: 7] (gated by blink, see below) and columns[col_idx] is driven 0.
- SHOW:
  - Outputs are held constant; the image is sampled once per slot only.
  - When slot_cnt==CLK_DIV-1: go to BLANK, slot_cnt=0, columns=all 1, rows=0.
  - On that same edge, col_idx increments; 4 wraps to 0.
- Frame wrap (the edge where col_idx goes 4->0), all on the same edge:
  - status_frame <= irrigation_status.
  - frame_start=1 for exactly the following cycle.
  - frame_cnt increments.
  - If frame_cnt reaches BLINK_FRAMES-1: frame_cnt=0 and blink_on toggles.
- Any change on irrigation_status within a frame is ignored until the next wrap. The first frame after reset displays status 2'b00.
- Decoder settling: status_frame changes only at the start of column 0's BLANK. The combinational decoders therefore have at least BLANK_CYCLES cycles to settle before column_images is sampled.
- Blink:
  - When status_frame==2'b11 and blink_on==0, rows loads 0 at the BLANK->SHOW edge; columns still scan normally.
  - For any other status_frame, blink_on is forced to 1 and frame_cnt to 0 at the frame wrap. This makes a newly latched fault start in the visible phase.
- Timing:
  - Slot = CLK_DIV cycles; frame = 5*CLK_DIV cycles.
  - First column low at cycle BLANK_CYCLES after reset deassertion.
- Invariants:
  - columns never has more than one 0 bit.
  - rows is nonzero only while a column is low.

Decomposition:
- Shared package (led_matrix_pkg):
  - NUM_COLS=5, NUM_ROWS=7.
  - Status codes: ST_IDLE=2'b00, ST_WATERING=2'b01, ST_DONE=2'b10, ST_FAULT=2'b11.
  - State encodings BLANK/SHOW.
- One natural sub-module, led_matrix_blink_timer: owns frame_cnt and blink_on. Inputs are frame_wrap and fault; output is blink_on.
- The five column decoders stay outside this block and are wired at the matrix top level.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2):
- Reset, then column_images = 35'h1_2345_6789 -> columns 11110 at cycles 2..7 with rows 7'h09; then 11101 at cycles 10..15 with rows 7'h4F (bits [13:7]); all ones at cycles 0..1 and 8..9.
- Full frame -> column order 0,1,2,3,4,0; frame_start high exactly at cycle 40; one-hot-low check on columns every cycle.
- irrigation_status 00->01 at cycle 13 -> status_frame stays 00 until the edge at cycle 40, then 01; frame_start pulses once.
- irrigation_status=11 held -> frame 1 shows rows; after BLINK_FRAMES=2 frames rows=0 for 2 frames while columns still scan; status 10 -> rows visible from the next frame.
- Reset asserted at cycle 21 (column 2 SHOW) -> next cycle columns=11111, rows=0, status_frame=00; column 0 low again 2 cycles after reset deasserts.
- Image change mid-SHOW (column_images bits [6:0] altered at cycle 4) -> rows unchanged until column 0's next slot.
